// File: rtl/fifo_wp_ctrl.sv
// Write-pointer controller for the packet FIFO: stores framed packets and publishes WP only on commit.
// Optional macro FIFO_WP_DROP_CNT_EN adds a saturating 16-bit dropped-packet counter (drop_cnt).
//
// Handshake: a beat is taken on every posedge where in_valid is high; in_ready is tied high
// because overflow is handled by dropping whole packets rather than by backpressure.
module fifo_wp_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_first,
  input  logic              in_last,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] RP,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0] WP,
  output logic              full,
  output logic [ADDR_W-1:0] free_cnt,
  output logic              pkt_done,
  output logic              pkt_drop,
`ifdef FIFO_WP_DROP_CNT_EN
  output logic [15:0]       drop_cnt,
`endif
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IN_PKT = 2'd1,
    DROP   = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wp_work, wp_work_d;
  // End of the last committed packet; WP trails it by one cycle while a commit is in flight.
  logic [ADDR_W-1:0]   wp_base, wp_base_d;
  logic [ADDR_W-1:0]   commit_ptr, commit_ptr_d;
  logic                commit_pend, commit_d;
  logic                we_d, drop_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   wdata_d;
  logic                full_base;

  assign in_ready  = 1'b1;
  assign full      = ((wp_work + ONE) == RP);
  assign free_cnt  = RP - wp_work - ONE;
  assign full_base = ((wp_base + ONE) == RP);
  assign state_dbg = state_q;

  always_comb begin
    state_d      = state_q;
    wp_work_d    = wp_work;
    wp_base_d    = wp_base;
    commit_ptr_d = commit_ptr;
    commit_d     = 1'b0;
    we_d         = 1'b0;
    drop_d       = 1'b0;
    addr_d       = mem_addr;
    wdata_d      = mem_wdata;
    if (in_valid) begin
      if (in_first) begin
        // A first beat outside IDLE aborts whatever was in progress; restart from wp_base.
        drop_d = (state_q != IDLE);
        if (!full_base) begin
          we_d      = 1'b1;
          addr_d    = wp_base;
          wdata_d   = in_data;
          wp_work_d = wp_base + ONE;
          if (in_last) begin
            commit_d     = 1'b1;
            commit_ptr_d = wp_base + ONE;
            wp_base_d    = wp_base + ONE;
            state_d      = IDLE;
          end else begin
            state_d = IN_PKT;
          end
        end else begin
          wp_work_d = wp_base;
          if (in_last) begin
            drop_d  = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = DROP;
          end
        end
      end else begin
        case (state_q)
          IN_PKT: begin
            if (!full) begin
              we_d      = 1'b1;
              addr_d    = wp_work;
              wdata_d   = in_data;
              wp_work_d = wp_work + ONE;
              if (in_last) begin
                commit_d     = 1'b1;
                commit_ptr_d = wp_work + ONE;
                wp_base_d    = wp_work + ONE;
                state_d      = IDLE;
              end
            end else begin
              wp_work_d = wp_base;
              if (in_last) begin
                drop_d  = 1'b1;
                state_d = IDLE;
              end else begin
                state_d = DROP;
              end
            end
          end
          DROP: begin
            if (in_last) begin
              drop_d  = 1'b1;
              state_d = IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wp_work     <= '0;
      wp_base     <= '0;
      WP          <= '0;
      commit_ptr  <= '0;
      commit_pend <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      pkt_done    <= 1'b0;
      pkt_drop    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wp_work     <= wp_work_d;
      wp_base     <= wp_base_d;
      commit_ptr  <= commit_ptr_d;
      commit_pend <= commit_d;
      mem_we      <= we_d;
      mem_addr    <= addr_d;
      mem_wdata   <= wdata_d;
      pkt_drop    <= drop_d;
      pkt_done    <= commit_pend;
      // Publish one cycle after the last RAM write so the reader never sees unwritten data.
      if (commit_pend) WP <= commit_ptr;
    end
  end

`ifdef FIFO_WP_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt <= 16'd0;
    end else if (pkt_drop && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wp_ctrl.sv
// Directed bench for fifo_wp_ctrl: commit latency, rollback on full, wrap, abort and reset.
module tb_fifo_wp_ctrl;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_first = 1'b0;
  logic              in_last = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic [ADDR_W-1:0] RP = '0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [ADDR_W-1:0] WP;
  logic              full;
  logic [ADDR_W-1:0] free_cnt;
  logic              pkt_done;
  logic              pkt_drop;
  logic [1:0]        state_dbg;
`ifdef FIFO_WP_DROP_CNT_EN
  logic [15:0]       drop_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  fifo_wp_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last), .in_data(in_data), .RP(RP),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .WP(WP),
    .full(full), .free_cnt(free_cnt), .pkt_done(pkt_done), .pkt_drop(pkt_drop),
`ifdef FIFO_WP_DROP_CNT_EN
    .drop_cnt(drop_cnt),
`endif
    .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drivers: each returns 1 time unit after the edge that consumed the beat.
  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic beat(input logic f, input logic l, input logic [DATA_W-1:0] d);
    in_valid = 1'b1; in_first = f; in_last = l; in_data = d;
    @(posedge clk); #1;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    RP = 8'd0;
    do_reset();
    chk("rst_wp", WP, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_state", state_dbg, 0);
    chk("rst_free", free_cnt, 255);
    chk("rst_full", full, 0);
    chk("rst_ready", in_ready, 1);

    // Single-beat packet
    beat(1'b1, 1'b1, 64'hA5);
    chk("sb_we", mem_we, 1);
    chk("sb_addr", mem_addr, 0);
    chk("sb_data", mem_wdata, 64'hA5);
    chk("sb_wp_early", WP, 0);
    chk("sb_done_early", pkt_done, 0);
    idle_cycle();
    chk("sb_wp", WP, 1);
    chk("sb_done", pkt_done, 1);
    chk("sb_we_off", mem_we, 0);
    chk("sb_free", free_cnt, 254);
    idle_cycle();
    chk("sb_done_pulse", pkt_done, 0);

    // Non-first beat in IDLE is ignored
    beat(1'b0, 1'b1, 64'h55);
    chk("stray_we", mem_we, 0);
    idle_cycle();
    chk("stray_wp", WP, 1);
    chk("stray_done", pkt_done, 0);

    // 3-beat packet
    do_reset();
    beat(1'b1, 1'b0, 64'd1);
    chk("p3_a0", mem_addr, 0);
    chk("p3_d0", mem_wdata, 1);
    chk("p3_state", state_dbg, 1);
    beat(1'b0, 1'b0, 64'd2);
    chk("p3_a1", mem_addr, 1);
    chk("p3_wp_mid", WP, 0);
    beat(1'b0, 1'b1, 64'd3);
    chk("p3_a2", mem_addr, 2);
    chk("p3_d2", mem_wdata, 3);
    chk("p3_wp_hold", WP, 0);
    idle_cycle();
    chk("p3_wp", WP, 3);
    chk("p3_done", pkt_done, 1);

    // Overflow: wp_work=3, RP=6 leaves room for two beats only
    RP = 8'd6;
    #1;
    chk("ov_free0", free_cnt, 2);
    beat(1'b1, 1'b0, 64'd11);
    chk("ov_a0", mem_addr, 3);
    chk("ov_full0", full, 0);
    beat(1'b0, 1'b0, 64'd12);
    chk("ov_a1", mem_addr, 4);
    chk("ov_we1", mem_we, 1);
    chk("ov_full1", full, 1);
    beat(1'b0, 1'b0, 64'd13);
    chk("ov_we2", mem_we, 0);
    chk("ov_rollback_free", free_cnt, 2);
    chk("ov_state", state_dbg, 2);
    beat(1'b0, 1'b1, 64'd14);
    chk("ov_drop", pkt_drop, 1);
    chk("ov_we3", mem_we, 0);
    idle_cycle();
    chk("ov_drop_pulse", pkt_drop, 0);
    chk("ov_done", pkt_done, 0);
    chk("ov_wp", WP, 3);
    chk("ov_free", free_cnt, 2);
    chk("ov_state_idle", state_dbg, 0);

    // Wrap: fill to WP=254, then a 3-beat packet across the boundary
    RP = 8'd0;
    do_reset();
    beat(1'b1, 1'b0, 64'd0);
    for (int i = 1; i < 253; i++) beat(1'b0, 1'b0, 64'(i));
    beat(1'b0, 1'b1, 64'd253);
    chk("fill_addr", mem_addr, 253);
    idle_cycle();
    chk("fill_wp", WP, 254);
    RP = 8'd250;
    beat(1'b1, 1'b0, 64'hB0);
    chk("wr_a0", mem_addr, 254);
    beat(1'b0, 1'b0, 64'hB1);
    chk("wr_a1", mem_addr, 255);
    beat(1'b0, 1'b1, 64'hB2);
    chk("wr_a2", mem_addr, 0);
    chk("wr_d2", mem_wdata, 64'hB2);
    idle_cycle();
    chk("wr_wp", WP, 1);
    chk("wr_free", free_cnt, 248);

    // Abort: new first beat while in a packet
    RP = 8'd0;
    do_reset();
    beat(1'b1, 1'b0, 64'd21);
    beat(1'b0, 1'b0, 64'd22);
    chk("ab_a1", mem_addr, 1);
    beat(1'b1, 1'b0, 64'd31);
    chk("ab_drop", pkt_drop, 1);
    chk("ab_we", mem_we, 1);
    chk("ab_addr", mem_addr, 0);
    chk("ab_data", mem_wdata, 31);
    beat(1'b0, 1'b1, 64'd32);
    chk("ab_drop_pulse", pkt_drop, 0);
    chk("ab_a_last", mem_addr, 1);
    chk("ab_wp_hold", WP, 0);
    idle_cycle();
    chk("ab_wp", WP, 2);
    chk("ab_done", pkt_done, 1);

    // Reset in the middle of a packet
    beat(1'b1, 1'b0, 64'd41);
    chk("mr_we_pre", mem_we, 1);
    rst_n = 1'b0;
    in_valid = 1'b1; in_first = 1'b0; in_last = 1'b1; in_data = 64'd42;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    rst_n = 1'b1;
    chk("mr_wp", WP, 0);
    chk("mr_we", mem_we, 0);
    chk("mr_drop", pkt_drop, 0);
    chk("mr_state", state_dbg, 0);
    chk("mr_free", free_cnt, 255);
    idle_cycle();
    chk("mr_done", pkt_done, 0);
    chk("mr_drop2", pkt_drop, 0);

`ifdef FIFO_WP_DROP_CNT_EN
    // Three full-FIFO single-beat drops
    chk("dc_rst", drop_cnt, 0);
    RP = 8'd1;
    for (int i = 0; i < 3; i++) beat(1'b1, 1'b1, 64'(i));
    idle_cycle();
    idle_cycle();
    chk("dc_three", drop_cnt, 3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
